// File: rtl/btn_debounce_pkg.sv
//==============================================================================
// btn_debounce_pkg: state encoding and debounce-length constants.  Rev 1.0
//==============================================================================
`default_nettype none

package btn_debounce_pkg;

  localparam logic [1:0] ST_STABLE_LOW  = 2'b00;
  localparam logic [1:0] ST_WAIT_HIGH   = 2'b01;
  localparam logic [1:0] ST_STABLE_HIGH = 2'b10;
  localparam logic [1:0] ST_WAIT_LOW    = 2'b11;

  localparam int DEBOUNCE_CYCLES_SYNTH = 1000000;
  localparam int DEBOUNCE_CYCLES_SIM   = 4;

  typedef enum logic [1:0] {
    STABLE_LOW  = ST_STABLE_LOW,
    WAIT_HIGH   = ST_WAIT_HIGH,
    STABLE_HIGH = ST_STABLE_HIGH,
    WAIT_LOW    = ST_WAIT_LOW
  } deb_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
//==============================================================================
// btn_debounce_ch: one channel - 2-flop synchroniser, counter FSM, edge pulses.
// BTN_DEBOUNCE_FALL_EN adds the registered fall pulse.  Rev 1.0
//==============================================================================
`default_nettype none

module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int NB_COUNTER      = 20,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYNTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_o,
`ifdef BTN_DEBOUNCE_FALL_EN
  output logic fall_o,
`endif
  output logic rise_o
);

  localparam logic [NB_COUNTER-1:0] C_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

  logic                  sync1_q;
  logic                  sync2_q;
  logic [NB_COUNTER-1:0] cnt_q;
  deb_state_t            state_q;
  logic                  btn_q;
  logic                  rise_q;
`ifdef BTN_DEBOUNCE_FALL_EN
  logic                  fall_q;
`endif

  // Pulses default low every cycle so they last exactly one clock per commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= STABLE_LOW;
      btn_q   <= 1'b0;
      rise_q  <= 1'b0;
`ifdef BTN_DEBOUNCE_FALL_EN
      fall_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
`ifdef BTN_DEBOUNCE_FALL_EN
      fall_q  <= 1'b0;
`endif
      case (state_q)
        STABLE_LOW: begin
          if (sync2_q) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2_q) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == C_LAST) begin
            state_q <= STABLE_HIGH;
            btn_q   <= 1'b1;
            rise_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!sync2_q) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2_q) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == C_LAST) begin
            state_q <= STABLE_LOW;
            btn_q   <= 1'b0;
`ifdef BTN_DEBOUNCE_FALL_EN
            fall_q  <= 1'b1;
`endif
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STABLE_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn_o  = btn_q;
  assign rise_o = rise_q;
`ifdef BTN_DEBOUNCE_FALL_EN
  assign fall_o = fall_q;
`endif

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
//==============================================================================
// btn_debounce: NB_SW independent debounce channels; BTN_DEBOUNCE_FALL_EN
// exposes o_btn_fall.  Rev 1.0
//==============================================================================
`default_nettype none

module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int NB_SW           = 4,
  parameter int NB_COUNTER      = 20,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYNTH
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_btn,
  output logic [NB_SW-1:0] o_btn,
`ifdef BTN_DEBOUNCE_FALL_EN
  output logic [NB_SW-1:0] o_btn_fall,
`endif
  output logic [NB_SW-1:0] o_btn_rise
);

  for (genvar g = 0; g < NB_SW; g++) begin : g_ch
    btn_debounce_ch #(
      .NB_COUNTER      (NB_COUNTER),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i  (clock),
      .rst_i  (i_reset),
      .btn_i  (i_btn[g]),
      .btn_o  (o_btn[g]),
`ifdef BTN_DEBOUNCE_FALL_EN
      .fall_o (o_btn_fall[g]),
`endif
      .rise_o (o_btn_rise[g])
    );
  end

endmodule

`default_nettype wire
